// File: rtl/mem_loader_if.sv
// Byte-stream handshake bundle between a byte source and the memory loader.
// The source drives byte_valid/byte_in and the loader answers with byte_ready.
interface mem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_in,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_in,
    output byte_ready
  );
endinterface

// File: rtl/mem_loader.sv
// Memory loader: assembles an MSB-first byte stream into 16-bit words and
// writes them to a 256x16 RAM at addresses 0..255, with a registered
// synchronous read port for the downstream scan logic.
module mem_loader #(
  parameter int DEPTH  = 256,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_a_p,
  input  logic              start_load,
  input  logic              abort_load,
  mem_loader_if.slave       bus,
  input  logic [7:0]        rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic [7:0]        wr_addr,
  output logic [8:0]        word_count,
  output logic              busy,
  output logic              finished
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD_HI = 2'd1;
  localparam logic [1:0] ST_LOAD_LO = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [8:0]        word_count_q, word_count_d;
  logic [7:0]        hi_q, hi_d;
  logic              byte_ready_q, byte_ready_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  logic              xfer_s;
  logic              mem_we_s;
  logic [WORD_W-1:0] mem_wdata_s;

  // Storage is never reset so that a reset mid-load keeps completed words.
  logic [WORD_W-1:0] mem_q [0:DEPTH-1];

  assign xfer_s      = bus.byte_valid & byte_ready_q;
  assign mem_wdata_s = {hi_q, bus.byte_in};

  // Next-state, address/count and hi-byte capture for the load sequencer.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    hi_d         = hi_q;
    mem_we_s     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // abort_load is deliberately ignored here, so start wins a tie.
        if (start_load) begin
          state_d      = ST_LOAD_HI;
          wr_addr_d    = 8'd0;
          word_count_d = 9'd0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_HI: begin
        if (abort_load) begin
          state_d = ST_DONE;
        end else if (xfer_s) begin
          hi_d    = bus.byte_in;
          state_d = ST_LOAD_LO;
        end else begin
          state_d = ST_LOAD_HI;
        end
      end
      ST_LOAD_LO: begin
        // Abort beats a same-edge transfer: the pending hi byte is dropped.
        if (abort_load) begin
          state_d = ST_DONE;
        end else if (xfer_s) begin
          mem_we_s     = 1'b1;
          word_count_d = word_count_q + 9'd1;
          if (wr_addr_q == 8'd255) begin
            wr_addr_d = 8'd0;
            state_d   = ST_DONE;
          end else begin
            wr_addr_d = wr_addr_q + 8'd1;
            state_d   = ST_LOAD_HI;
          end
        end else begin
          state_d = ST_LOAD_LO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they register with it.
  always_comb begin
    byte_ready_d = (state_d == ST_LOAD_HI) || (state_d == ST_LOAD_LO);
    busy_d       = (state_d == ST_LOAD_HI) || (state_d == ST_LOAD_LO);
    finished_d   = (state_d == ST_DONE);
    rd_data_d    = mem_q[rd_addr];
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= 8'd0;
      word_count_q <= 9'd0;
      hi_q         <= 8'd0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      hi_q         <= hi_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // RAM write port; the read above samples old data on a same-address write.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_addr_q] <= mem_wdata_s;
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign rd_data        = rd_data_q;
  assign wr_addr        = wr_addr_q;
  assign word_count     = word_count_q;
  assign busy           = busy_q;
  assign finished       = finished_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: full load, a vector table for handshake
// gaps/abort/start priority, and hand-written sequences for start-while-busy,
// asynchronous reset mid-load and read/write collision.
module tb_mem_loader;

  logic        clk;
  logic        rst_a_p;
  logic        start_load;
  logic        abort_load;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [7:0]  wr_addr;
  logic [8:0]  word_count;
  logic        busy;
  logic        finished;

  int checks;
  int errors;

  mem_loader_if bif ();

  mem_loader dut (
    .clk        (clk),
    .rst_a_p    (rst_a_p),
    .start_load (start_load),
    .abort_load (abort_load),
    .bus        (bif.slave),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_addr    (wr_addr),
    .word_count (word_count),
    .busy       (busy),
    .finished   (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        abort;
    logic        valid;
    logic [7:0]  din;
    logic [7:0]  raddr;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_fin;
    logic [7:0]  exp_wr;
    logic [8:0]  exp_cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bif.byte_valid = 1'b1;
    bif.byte_in    = b;
    step();
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    bif.byte_valid = 1'b0;
  endtask

  function automatic logic [15:0] v4(input int w);
    logic [7:0] wb;
    wb = w[7:0];
    if (w == 7) return 16'h1111;
    else return {8'hA0 | wb, wb};
  endfunction

  function automatic logic [15:0] v5(input int w);
    logic [7:0] wb;
    wb = w[7:0];
    return {8'hC3, wb ^ 8'h5A};
  endfunction

  initial begin
    int ready_run;
    checks = 0;
    errors = 0;
    rst_a_p = 1'b1;
    start_load = 1'b0;
    abort_load = 1'b0;
    rd_addr = 8'd0;
    bif.byte_valid = 1'b0;
    bif.byte_in = 8'd0;

    // table: {start, abort, valid, din, raddr, chk_rd, exp_rd, ready, busy, fin, wr, cnt}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'hAB, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'hAB, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'hCD, 8'd0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd1, 9'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'hCD, 8'd0, 1'b1, 16'hABCD, 1'b1, 1'b1, 1'b0, 8'd1, 9'd1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, 8'd1, 9'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h12, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd0, 9'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h34, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd1, 9'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h56, 8'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 8'd1, 9'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h78, 8'd0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 8'd1, 9'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'd1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 8'd1, 9'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h99, 8'd1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1, 9'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'd1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 8'd1, 9'd1};

    // reset state while reset is held
    #3;
    chk("rst_ready", {31'd0, bif.byte_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_finished", {31'd0, finished}, 32'd0);
    chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    chk("rst_count", {23'd0, word_count}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    step();
    rst_a_p = 1'b0;
    step();
    chk("idle_ready", {31'd0, bif.byte_ready}, 32'd0);

    // full load of 256 words: word w = 16'h00ww
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    ready_run = 0;
    for (int i = 0; i < 512; i++) begin
      if (bif.byte_ready === 1'b1) ready_run = ready_run + 1;
      if (i == 511) chk("full_not_done_early", {31'd0, finished}, 32'd0);
      bif.byte_valid = 1'b1;
      bif.byte_in = (i % 2 == 0) ? 8'h00 : 8'(i / 2);
      step();
    end
    bif.byte_valid = 1'b0;
    chk("full_ready_run", ready_run, 32'd512);
    chk("full_finished", {31'd0, finished}, 32'd1);
    chk("full_count", {23'd0, word_count}, 32'd256);
    chk("full_wr_wrap", {24'd0, wr_addr}, 32'd0);
    chk("full_busy", {31'd0, busy}, 32'd0);
    chk("full_ready_off", {31'd0, bif.byte_ready}, 32'd0);
    rd_addr = 8'd0;   step(); chk("full_rd0", {16'd0, rd_data}, 32'h0000);
    rd_addr = 8'd128; step(); chk("full_rd128", {16'd0, rd_data}, 32'h0080);
    rd_addr = 8'd255; step(); chk("full_rd255", {16'd0, rd_data}, 32'h00FF);

    // vector table: valid gaps, abort discard, start-vs-abort, ignores in DONE
    for (int k = 0; k < 14; k++) begin
      start_load     = tbl[k].start;
      abort_load     = tbl[k].abort;
      bif.byte_valid = tbl[k].valid;
      bif.byte_in    = tbl[k].din;
      rd_addr        = tbl[k].raddr;
      step();
      chk($sformatf("tbl%0d_ready", k), {31'd0, bif.byte_ready}, {31'd0, tbl[k].exp_ready});
      chk($sformatf("tbl%0d_busy", k), {31'd0, busy}, {31'd0, tbl[k].exp_busy});
      chk($sformatf("tbl%0d_fin", k), {31'd0, finished}, {31'd0, tbl[k].exp_fin});
      chk($sformatf("tbl%0d_wr", k), {24'd0, wr_addr}, {24'd0, tbl[k].exp_wr});
      chk($sformatf("tbl%0d_cnt", k), {23'd0, word_count}, {23'd0, tbl[k].exp_cnt});
      if (tbl[k].chk_rd) chk($sformatf("tbl%0d_rd", k), {16'd0, rd_data}, {16'd0, tbl[k].exp_rd});
    end
    start_load = 1'b0;
    abort_load = 1'b0;
    bif.byte_valid = 1'b0;

    // restart from DONE, then start_load while busy is ignored
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk("restart_fin_drop", {31'd0, finished}, 32'd0);
    chk("restart_wr0", {24'd0, wr_addr}, 32'd0);
    for (int w = 0; w < 10; w++) send_word(v4(w));
    start_load = 1'b1;
    send_byte(v4(10) >> 8);
    start_load = 1'b0;
    chk("busy_start_wr", {24'd0, wr_addr}, 32'd10);
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    send_byte(v4(10) & 16'hFF);
    bif.byte_valid = 1'b0;
    chk("busy_start_wr11", {24'd0, wr_addr}, 32'd11);
    chk("busy_start_cnt11", {23'd0, word_count}, 32'd11);
    abort_load = 1'b1;
    step();
    abort_load = 1'b0;
    chk("abort2_fin", {31'd0, finished}, 32'd1);
    chk("abort2_cnt", {23'd0, word_count}, 32'd11);

    // asynchronous reset mid-load at word 5 with a pending hi byte
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    for (int w = 0; w < 5; w++) send_word(v5(w));
    send_byte(8'hEE);
    bif.byte_valid = 1'b0;
    #2 rst_a_p = 1'b1;
    #1;
    chk("arst_ready", {31'd0, bif.byte_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_wr", {24'd0, wr_addr}, 32'd0);
    chk("arst_cnt", {23'd0, word_count}, 32'd0);
    chk("arst_rd", {16'd0, rd_data}, 32'd0);
    #1 rst_a_p = 1'b0;
    for (int a = 0; a < 6; a++) begin
      rd_addr = 8'(a);
      step();
      chk($sformatf("arst_mem%0d", a), {16'd0, rd_data}, {16'd0, (a < 5) ? v5(a) : v4(a)});
    end
    chk("arst_idle_ready", {31'd0, bif.byte_ready}, 32'd0);

    // read-before-write collision at address 7 (old 0x1111)
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    for (int w = 0; w < 7; w++) send_word(16'h6000 + 16'(w));
    rd_addr = 8'd7;
    send_byte(8'hBE);
    send_byte(8'hEF);
    bif.byte_valid = 1'b0;
    chk("coll_old", {16'd0, rd_data}, 32'h1111);
    step();
    chk("coll_new", {16'd0, rd_data}, 32'hBEEF);
    chk("coll_wr8", {24'd0, wr_addr}, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
